// File: rtl/fetch_control.sv
// rtl/fetch_control.sv - instruction fetch sequencer with pipeline controls and perf counters
//
// Sequences free-running (RUN) and single-step (STEP) fetch, parks in HALTED on a
// debug or opcode halt, and drives the IF-stage pipeline enables.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   start, step           enter RUN / fetch exactly one instruction (from IDLE)
//   halt_req, halt_instr  debug halt request / decoded halt opcode
//   clear                 leave HALTED and zero the counters
//   branch_taken          resolved taken branch (target on the branch path)
//   load_use_hazard       one-cycle stall request from the hazard unit
//   PCSrc, PCWrite        fetch mux select, PC enable
//   IF_ID_Write, IF_Flush IF/ID enable, IF/ID flush
//   state                 IDLE=00 RUN=01 STEP=10 HALTED=11
//   fetch_count, stall_count, flush_count  saturating performance counters

module fetch_control #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             halt_instr,
  input  logic             clear,
  input  logic             branch_taken,
  input  logic             load_use_hazard,
  output logic             PCSrc,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_Flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fetch_q, fetch_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic active;
  logic halt_any;
  logic stall_now;
  logic clear_now;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      fetch_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Next state and pipeline controls. Controls follow the inputs with no
  // latency while fetching; a halt seen this cycle still lets this cycle's
  // controls through because they depend only on the current state.
  always_comb begin
    state_d     = state_q;
    active      = (state_q == S_RUN) || (state_q == S_STEP);
    halt_any    = halt_req || halt_instr;
    PCSrc       = 1'b0;
    IF_Flush    = 1'b0;
    PCWrite     = 1'b0;
    IF_ID_Write = 1'b0;

    if (active) begin
      // A taken branch overrides a load-use stall: the stalled instruction
      // is on the wrong path and is flushed anyway.
      PCSrc       = branch_taken;
      IF_Flush    = branch_taken;
      PCWrite     = branch_taken || !load_use_hazard;
      IF_ID_Write = branch_taken || !load_use_hazard;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end else if (step) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (halt_any) begin
          state_d = S_HALTED;
        end
      end
      S_STEP: begin
        state_d = halt_any ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (clear) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counters saturate instead of wrapping. Clear only acts from HALTED, where
  // the controls are all 0, so it never competes with an increment.
  always_comb begin
    stall_now = active && load_use_hazard && !branch_taken;
    clear_now = (state_q == S_HALTED) && clear;
    fetch_d   = fetch_q;
    stall_d   = stall_q;
    flush_d   = flush_q;

    if (clear_now) begin
      fetch_d = '0;
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (PCWrite && (fetch_q != CNT_MAX)) begin
        fetch_d = fetch_q + CNT_ONE;
      end
      if (stall_now && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + CNT_ONE;
      end
      if (IF_Flush && (flush_q != CNT_MAX)) begin
        flush_d = flush_q + CNT_ONE;
      end
    end
  end

  assign state       = state_q;
  assign fetch_count = fetch_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter CNT_W, default 16, is the width of every performance counter.
REQ-002 Port clock, input, 1: single clock, all state updates on the rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port start, input, 1: begin free-running fetch.
REQ-005 Port step, input, 1: advance fetch by exactly one instruction.
REQ-006 Port halt_req, input, 1: external debug halt request.
REQ-007 Port halt_instr, input, 1: decode stage reports a halt opcode.
REQ-008 Port clear, input, 1: leave HALTED and zero the counters.
REQ-009 Port branch_taken, input, 1: resolved taken branch, target valid on the pc_salto path.
REQ-010 Port load_use_hazard, input, 1: hazard unit requests a one-cycle stall.
REQ-011 Port PCSrc, output, 1: fetch mux select (1 = branch target).
REQ-012 Port PCWrite, output, 1: PC register enable.
REQ-013 Port IF_ID_Write, output, 1: IF/ID register enable.
REQ-014 Port IF_Flush, output, 1: IF/ID register flush.
REQ-015 Port state, output, 2: IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-016 Port fetch_count, output, CNT_W: number of cycles with PCWrite=1.
REQ-017 Port stall_count, output, CNT_W: number of stall cycles.
REQ-018 Port flush_count, output, CNT_W: number of flush cycles.

Function
REQ-019 From IDLE: start moves to RUN; otherwise step moves to STEP; start has priority over step.
REQ-020 From RUN: halt_req or halt_instr moves to HALTED; otherwise the state stays RUN.
REQ-021 STEP lasts exactly one cycle, then moves to IDLE, or to HALTED if halt_req or halt_instr is high in that cycle.
REQ-022 From HALTED: clear moves to IDLE; start, step and halt_req are ignored.
REQ-023 In IDLE and HALTED, all four pipeline controls (PCSrc, PCWrite, IF_ID_Write, IF_Flush) are held at 0.
REQ-024 In RUN and STEP, the controls are combinational from the current inputs:
  - PCSrc = branch_taken
  - IF_Flush = branch_taken
  - PCWrite = branch_taken OR NOT load_use_hazard
  - IF_ID_Write = NOT load_use_hazard OR branch_taken
REQ-025 A branch_taken and load_use_hazard in the same cycle resolve to the branch: redirect, flush, no stall.
REQ-026 A halt entered in a given cycle still applies that cycle's controls; the controls go to 0 from the next cycle.
REQ-027 Counter increment rules, evaluated per cycle:
  - fetch_count increments when PCWrite=1
  - stall_count increments in RUN/STEP when load_use_hazard=1 and branch_taken=0
  - flush_count increments when IF_Flush=1
REQ-028 All counters saturate at 2^CNT_W-1 and do not wrap.
REQ-029 clear in HALTED zeroes all counters on the same edge that enters IDLE; clear in any other state has no effect.
REQ-030 There is no latency from inputs to pipeline controls; the state and counters update on the next rising edge.

Reset
REQ-031 While reset=0, regardless of clock:
  - state is IDLE
  - all counters are 0
  - PCSrc, PCWrite, IF_ID_Write and IF_Flush are 0
REQ-032 Reset asserted mid-RUN aborts immediately, with no pending step or halt retained.
REQ-033 After reset deasserts, the first transition occurs on the first rising edge with start or step high.

Verification
REQ-034 Reset release, start pulse, 10 idle cycles -> state=01, PCWrite=1 every cycle, fetch_count=10.
REQ-035 RUN with load_use_hazard=1 for 1 cycle -> PCWrite=0 and IF_ID_Write=0 that cycle, stall_count=1.
REQ-036 RUN with branch_taken=1 and load_use_hazard=1 together -> PCSrc=1, IF_Flush=1, PCWrite=1, stall_count unchanged, flush_count=1.
REQ-037 IDLE, step pulse -> exactly one cycle with PCWrite=1, then state=00, fetch_count=1.
REQ-038 RUN, halt_instr=1 -> state=11 next cycle with controls at 0; start ignored; clear -> state=00 and all counters 0.
REQ-039 CNT_W=4, run 20 cycles -> fetch_count holds at 15; reset mid-run -> all outputs 0 asynchronously.
